// File: rtl/frequency_scan_pkg.sv
// Shared types and constants for the frequency scan controller.
package frequency_scan_pkg;

   localparam int FREQ_WIDTH  = 30;
   localparam int LIMIT_WIDTH = 24;
   localparam int LIMIT_SHIFT = 6;

   localparam logic [LIMIT_WIDTH-1:0] LOW_LIMIT_RESET  = '0;
   localparam logic [LIMIT_WIDTH-1:0] HIGH_LIMIT_RESET = '1;

   typedef enum logic [1:0] {
      OP_READBACK = 2'b00,
      OP_SET_LOW  = 2'b01,
      OP_SET_HIGH = 2'b10,
      OP_CLEAR    = 2'b11
   } scanOp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE
   } scanState_t;

   // Width of a channel select for nf channels (at least one bit).
   function automatic int selWidth(input int nf);
      return (nf <= 1) ? 1 : $clog2(nf);
   endfunction

endpackage

// File: rtl/frequency_limit_check.sv
// Window compare of a scaled frequency against one channel's limits.
// The limit operands come straight from the held limit registers, so a
// limit write landing in the capture cycle is not yet visible here.
module frequency_limit_check
   import frequency_scan_pkg::*;
(
   input  logic [LIMIT_WIDTH-1:0] freqScaled,
   input  logic [LIMIT_WIDTH-1:0] lowLimit,
   input  logic [LIMIT_WIDTH-1:0] highLimit,
   output logic                   oor
);

   // Out of range when strictly below low or strictly above high
   always_comb begin
      oor = (freqScaled < lowLimit) || (freqScaled > highLimit);
   end

endmodule

// File: rtl/frequency_scan_controller.sv
// Steps the counter readout select through all channels on each
// acquisition marker, snapshots each measurement and flags limit alarms.
module frequency_scan_controller
   import frequency_scan_pkg::*;
#(
   parameter int    NF     = 4,
   parameter int    SETTLE = 3,
   parameter string DEBUG  = "false",
   localparam int   SW     = selWidth(NF)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ppsStrobe,
   input  logic [FREQ_WIDTH-1:0] measuredFrequency,
   output logic [SW-1:0]         monitorSelect,
   input  logic                  csrStrobe,
   input  logic [31:0]           GPIO_OUT,
   output logic [31:0]           status,
   output logic [NF-1:0]         alarmsSticky,
   output logic [NF-1:0]         alarmsLive,
   output logic                  scanBusy,
   output logic                  scanDone,
   output logic                  overrun
);

   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
   localparam logic [SW-1:0] LAST_CH  = SW'(NF - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

   (* mark_debug = DEBUG *) scanState_t    state;
   scanState_t                             nextState;
   (* mark_debug = DEBUG *) logic [SW-1:0] ch;
   logic [CW-1:0]                          settleCnt;
   logic                                   pending;
   logic                                   captureEn;
   logic                                   startScan;
   logic                                   settleLast;
   logic                                   lastCh;
   logic                                   oor;

   logic [FREQ_WIDTH-1:0]  snapshot  [NF];
   logic [NF-1:0]          valid;
   logic [LIMIT_WIDTH-1:0] lowLimit  [NF];
   logic [LIMIT_WIDTH-1:0] highLimit [NF];
   logic [SW-1:0]          rbSel;

   scanOp_t                cmdOp;
   logic [5:0]             cmdCh;
   logic [LIMIT_WIDTH-1:0] cmdValue;
   logic [SW-1:0]          cmdIdx;
   logic                   cmdAccept;
   logic                   clearCmd;

   assign cmdOp     = scanOp_t'(GPIO_OUT[31:30]);
   assign cmdCh     = GPIO_OUT[29:24];
   assign cmdValue  = GPIO_OUT[23:0];
   assign cmdIdx    = cmdCh[SW-1:0];
   assign cmdAccept = csrStrobe && ({26'd0, cmdCh} < 32'(NF));
   assign clearCmd  = cmdAccept && (cmdOp == OP_CLEAR);

   assign settleLast    = (state == ST_SETTLE) && (settleCnt == LAST_CNT);
   assign lastCh        = (ch == LAST_CH);
   assign monitorSelect = ch;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nextState;
   end

   // Next-state logic: idle -> settle -> capture, looping per channel
   always_comb begin
      nextState = state;
      unique case (state)
         ST_IDLE:    if (ppsStrobe || pending) nextState = ST_SETTLE;
         ST_SETTLE:  if (settleLast) nextState = ST_CAPTURE;
         ST_CAPTURE: nextState = lastCh ? ST_IDLE : ST_SETTLE;
         default:    nextState = ST_IDLE;
      endcase
   end

   // State-decoded controls
   always_comb begin
      scanBusy  = (state != ST_IDLE);
      captureEn = (state == ST_CAPTURE);
      startScan = (state == ST_IDLE) && (ppsStrobe || pending);
   end

   // Settle counter runs only while settling
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 settleCnt <= '0;
      else if (state != ST_SETTLE) settleCnt <= '0;
      else if (settleLast)        settleCnt <= '0;
      else                        settleCnt <= settleCnt + 1'b1;
   end

   // Channel pointer, which is also the counter readout select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   ch <= '0;
      else if (startScan)           ch <= '0;
      else if (captureEn && !lastCh) ch <= ch + 1'b1;
   end

   // Pending rescan and sticky overrun; a new overrun beats a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (startScan)                 pending <= 1'b0;
         else if (scanBusy && ppsStrobe) pending <= 1'b1;
         if (scanBusy && ppsStrobe && pending) overrun <= 1'b1;
         else if (clearCmd)                   overrun <= 1'b0;
      end
   end

   // Completion pulse the cycle after the last capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) scanDone <= 1'b0;
      else        scanDone <= captureEn && lastCh;
   end

   // Limit registers and readback select written from the command port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NF; i++) begin
            lowLimit[i]  <= LOW_LIMIT_RESET;
            highLimit[i] <= HIGH_LIMIT_RESET;
         end
         rbSel <= '0;
      end else if (cmdAccept) begin
         unique case (cmdOp)
            OP_READBACK: rbSel             <= cmdIdx;
            OP_SET_LOW:  lowLimit[cmdIdx]  <= cmdValue;
            OP_SET_HIGH: highLimit[cmdIdx] <= cmdValue;
            default:     ;
         endcase
      end
   end

   frequency_limit_check u_limitCheck (
      .freqScaled (measuredFrequency[FREQ_WIDTH-1:LIMIT_SHIFT]),
      .lowLimit   (lowLimit[ch]),
      .highLimit  (highLimit[ch]),
      .oor        (oor)
   );

   // Snapshot bank and live alarm capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NF; i++) snapshot[i] <= '0;
         valid      <= '0;
         alarmsLive <= '0;
      end else if (captureEn) begin
         snapshot[ch]   <= measuredFrequency;
         valid[ch]      <= 1'b1;
         alarmsLive[ch] <= oor;
      end
   end

   // Sticky alarms: the later capture assignment overrides a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarmsSticky <= '0;
      end else begin
         if (clearCmd)         alarmsSticky     <= '0;
         if (captureEn && oor) alarmsSticky[ch] <= 1'b1;
      end
   end

   assign status = {alarmsSticky[rbSel], valid[rbSel], snapshot[rbSel]};

endmodule
